// File: rtl/gp_pkg.sv
// gp_reg_machine shared types: sizes, opcodes, FSM states, instruction word.
// GP_ARITH_EN (optional) enables ADD/SUB opcodes inside gp_alu.
package gp_pkg;
  localparam int WIDTH      = 16;
  localparam int NREGS      = 4;
  localparam int PROG_DEPTH = 32;
  localparam int IDXW       = $clog2(NREGS);
  localparam int PCW        = $clog2(PROG_DEPTH);

  function automatic int iw_calc(input int idxw);
    return 4 + 2 * idxw;
  endfunction

  localparam int IW = iw_calc(IDXW);

  typedef logic [NREGS-1:0][WIDTH-1:0] rvec_t;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_MOV,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_LNOT,
    OP_ADD,
    OP_SUB
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef struct packed {
    op_e             op;
    logic [IDXW-1:0] dst;
    logic            src_in;
    logic [IDXW-1:0] src;
  } instr_t;
endpackage

// File: rtl/gp_reg_machine_if.sv
// Loader/comparator bus of gp_reg_machine: program port, run control, result.
// master = loader/comparator side, slave = the machine.
interface gp_reg_machine_if;
  import gp_pkg::*;

  logic           prog_we;
  logic [PCW-1:0] prog_waddr;
  logic [IW-1:0]  prog_wdata;
  logic [PCW:0]   prog_len;
  rvec_t          in_vec;
  logic           start;
  logic           busy;
  logic           done;
  rvec_t          y;

  modport master (
    output prog_we, prog_waddr, prog_wdata,
    output prog_len, in_vec, start,
    input  busy, done, y
  );

  modport slave (
    input  prog_we, prog_waddr, prog_wdata,
    input  prog_len, in_vec, start,
    output busy, done, y
  );
endinterface

// File: rtl/gp_alu.sv
// Combinational op unit: result for r[dst] from its old value and operand s.
// GP_ARITH_EN builds the ADD/SUB adder; otherwise opcodes 6/7 act as NOP.
module gp_alu
  import gp_pkg::*;
(
  input  op_e              op_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] s_i,
  output logic [WIDTH-1:0] res_o
);
  always_comb begin
    res_o = r_i;
    unique case (1'b1)
      (op_i == OP_MOV):  res_o = s_i;
      (op_i == OP_AND):  res_o = r_i & s_i;
      (op_i == OP_OR):   res_o = r_i | s_i;
      (op_i == OP_XOR):  res_o = r_i ^ s_i;
      (op_i == OP_LNOT): res_o = {{(WIDTH-1){1'b0}}, ~|s_i};
`ifdef GP_ARITH_EN
      (op_i == OP_ADD):  res_o = r_i + s_i;
      (op_i == OP_SUB):  res_o = r_i - s_i;
`endif
      default:           res_o = r_i;
    endcase
  end
endmodule

// File: rtl/gp_reg_machine.sv
// Register-machine interpreter: FSM, register file, program memory, pc.
// Opcodes 6/7 depend on GP_ARITH_EN (see gp_alu).
module gp_reg_machine
  import gp_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  gp_reg_machine_if.slave bus
);
  localparam logic [PCW:0] DEPTH = (PCW+1)'(PROG_DEPTH);
  localparam logic [PCW:0] ONE   = (PCW+1)'(1);

  state_e           state_q;
  logic [PCW:0]     pc_q;
  logic [PCW:0]     len_q;
  logic [PCW:0]     len_d;
  rvec_t            r_q;
  rvec_t            y_q;
  logic             done_q;
  instr_t           mem_q [PROG_DEPTH];
  instr_t           cur;
  logic [WIDTH-1:0] s_val;
  logic [WIDTH-1:0] alu_res;

  assign len_d = (bus.prog_len > DEPTH) ? DEPTH : bus.prog_len;
  assign cur   = mem_q[pc_q[PCW-1:0]];
  // in_vec operands read the live port, not the seeded copy
  assign s_val = cur.src_in ? bus.in_vec[cur.src] : r_q[cur.src];

  gp_alu u_alu (
    .op_i  (cur.op),
    .r_i   (r_q[cur.dst]),
    .s_i   (s_val),
    .res_o (alu_res)
  );

  always_ff @(posedge clk) begin
    if (bus.prog_we && state_q == S_IDLE)
      mem_q[bus.prog_waddr] <= instr_t'(bus.prog_wdata);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      r_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            r_q     <= bus.in_vec;
            pc_q    <= '0;
            len_q   <= len_d;
            state_q <= (len_d != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          r_q[cur.dst] <= alu_res;
          pc_q         <= pc_q + ONE;
          if (pc_q == len_q - ONE)
            state_q <= S_DONE;
        end
        S_DONE: begin
          y_q     <= r_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.y    = y_q;
endmodule
